// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_stage_lsu_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned BEAT_BYTES = 8;

  typedef logic [XLEN-1:0] dw;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Byte mask of an access of 1/2/4/8 bytes, LSB-aligned.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load data alignment: shifts the two-beat window down to the access
// offset, truncates to the access size and sign/zero extends.
module lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  dw          rdata_lo,
  input  dw          rdata_hi,
  input  logic [2:0] offset,
  input  logic [2:0] funct3,
  output dw          data_c
);

  dw sh_c;
  assign sh_c = XLEN'({rdata_hi, rdata_lo} >> {offset, 3'b000});

  always_comb begin
    data_c = sh_c;
    case (funct3)
      F3_B:    data_c = {{56{sh_c[7]}},  sh_c[7:0]};
      F3_H:    data_c = {{48{sh_c[15]}}, sh_c[15:0]};
      F3_W:    data_c = {{32{sh_c[31]}}, sh_c[31:0]};
      F3_D:    data_c = sh_c;
      F3_BU:   data_c = {56'b0, sh_c[7:0]};
      F3_HU:   data_c = {48'b0, sh_c[15:0]};
      F3_WU:   data_c = {32'b0, sh_c[31:0]};
      default: data_c = sh_c;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: valid/ready data-memory requests, split
// accesses across 8-byte beats, load alignment and pipeline stall.
module mem_stage_lsu #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned BEAT_BYTES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read_M,
  input  logic            mem_write_M,
  input  logic [2:0]      funct3_M,
  input  logic [XLEN-1:0] alu_out_M,
  input  logic [XLEN-1:0] rs2_data_M,
  input  logic [XLEN-1:0] current_pc_M,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_we,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [7:0]      dmem_req_strb,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_rdata,
  input  logic            dmem_rsp_err,
  output logic            lsu_stall,
  output logic            lsu_done,
  output logic [XLEN-1:0] load_data_M,
  output logic            lsu_fault,
  output logic [XLEN-1:0] fault_pc,
  output logic [XLEN-1:0] fault_addr
);

  import mem_stage_lsu_pkg::*;

  localparam logic [1:0] ST_IDLE = LSU_IDLE;
  localparam logic [1:0] ST_REQ  = LSU_REQ;
  localparam logic [1:0] ST_WAIT = LSU_WAIT;
  localparam logic [1:0] ST_DONE = LSU_DONE;

  logic [1:0]      state_q, state_d;
  logic            is_load_q, is_load_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdat_q, wdat_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            beat2_q, beat2_d;
  logic [XLEN-1:0] rdata1_q, rdata1_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;

  logic [2:0]        offset_c;
  logic [15:0]       strb16_c;
  logic              split_c;
  logic [2*XLEN-1:0] wide_c;
  logic [XLEN-1:0]   beat_addr_c;
  logic [XLEN-1:0]   align_lo_c, align_hi_c, align_c;
  logic              op_c, illegal_c;

  // Lane geometry of the captured access; upper strobe byte means a second beat.
  assign offset_c    = addr_q[2:0];
  assign strb16_c    = {8'b0, size_mask(f3_q[1:0])} << offset_c;
  assign split_c     = |strb16_c[15:8];
  assign wide_c      = {XLEN'(0), wdat_q} << {offset_c, 3'b000};
  assign beat_addr_c = {addr_q[XLEN-1:3], 3'b000} + (beat2_q ? XLEN'(BEAT_BYTES) : XLEN'(0));

  assign op_c      = mem_read_M | mem_write_M;
  assign illegal_c = mem_read_M ? (funct3_M == 3'b111) : funct3_M[2];

  // The final beat is the live response; beat 1 data is held when split.
  assign align_lo_c = beat2_q ? rdata1_q : dmem_rsp_rdata;
  assign align_hi_c = beat2_q ? dmem_rsp_rdata : XLEN'(0);

  lsu_load_align u_align (
    .rdata_lo (align_lo_c),
    .rdata_hi (align_hi_c),
    .offset   (offset_c),
    .funct3   (f3_q),
    .data_c   (align_c)
  );

  always_comb begin
    state_d      = state_q;
    is_load_d    = is_load_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdat_d       = wdat_q;
    pc_d         = pc_q;
    beat2_d      = beat2_q;
    rdata1_d     = rdata1_q;
    load_data_d  = load_data_q;
    fault_d      = 1'b0;
    fault_pc_d   = fault_pc_q;
    fault_addr_d = fault_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (op_c) begin
          is_load_d = mem_read_M;
          f3_d      = funct3_M;
          addr_d    = alu_out_M;
          wdat_d    = rs2_data_M;
          pc_d      = current_pc_M;
          beat2_d   = 1'b0;
          if (illegal_c) begin
            state_d      = ST_DONE;
            fault_d      = 1'b1;
            fault_pc_d   = current_pc_M;
            fault_addr_d = alu_out_M;
            load_data_d  = '0;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dmem_rsp_valid) begin
          if (dmem_rsp_err) begin
            state_d      = ST_DONE;
            fault_d      = 1'b1;
            fault_pc_d   = pc_q;
            fault_addr_d = addr_q;
            load_data_d  = '0;
          end else if (split_c && !beat2_q) begin
            state_d  = ST_REQ;
            beat2_d  = 1'b1;
            rdata1_d = dmem_rsp_rdata;
          end else begin
            state_d     = ST_DONE;
            load_data_d = is_load_q ? align_c : XLEN'(0);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      is_load_q    <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdat_q       <= '0;
      pc_q         <= '0;
      beat2_q      <= 1'b0;
      rdata1_q     <= '0;
      load_data_q  <= '0;
      fault_q      <= 1'b0;
      fault_pc_q   <= '0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      is_load_q    <= is_load_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdat_q       <= wdat_d;
      pc_q         <= pc_d;
      beat2_q      <= beat2_d;
      rdata1_q     <= rdata1_d;
      load_data_q  <= load_data_d;
      fault_q      <= fault_d;
      fault_pc_q   <= fault_pc_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Request fields are pure decodes of held state, so they stay stable under backpressure.
  assign dmem_req_valid = (state_q == ST_REQ);
  assign dmem_req_we    = dmem_req_valid & ~is_load_q;
  assign dmem_req_addr  = dmem_req_valid ? beat_addr_c : XLEN'(0);
  assign dmem_req_wdata = !dmem_req_valid ? XLEN'(0) :
                          beat2_q ? wide_c[2*XLEN-1:XLEN] : wide_c[XLEN-1:0];
  assign dmem_req_strb  = !dmem_req_valid ? 8'h00 :
                          beat2_q ? strb16_c[15:8] : strb16_c[7:0];

  assign lsu_stall   = ~rst & ((state_q == ST_IDLE & op_c) | (state_q == ST_REQ) |
                               (state_q == ST_WAIT));
  assign lsu_done    = (state_q == ST_DONE);
  assign lsu_fault   = fault_q;
  assign load_data_M = load_data_q;
  assign fault_pc    = fault_pc_q;
  assign fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a one-cycle-latency memory responder.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic        mem_read_M, mem_write_M;
  logic [2:0]  funct3_M;
  logic [63:0] alu_out_M, rs2_data_M, current_pc_M;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [63:0] dmem_req_addr, dmem_req_wdata;
  logic [7:0]  dmem_req_strb;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rsp_rdata;
  logic        dmem_rsp_err;
  logic        lsu_stall, lsu_done, lsu_fault;
  logic [63:0] load_data_M, fault_pc, fault_addr;

  mem_stage_lsu dut (
    .clk(clk), .rst(rst),
    .mem_read_M(mem_read_M), .mem_write_M(mem_write_M), .funct3_M(funct3_M),
    .alu_out_M(alu_out_M), .rs2_data_M(rs2_data_M), .current_pc_M(current_pc_M),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_strb(dmem_req_strb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .dmem_rsp_err(dmem_rsp_err),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .load_data_M(load_data_M),
    .lsu_fault(lsu_fault), .fault_pc(fault_pc), .fault_addr(fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder controls and request log
  logic [63:0] rd0, rd1;
  int          err_beat;
  logic        no_rsp, inject_rsp, clr_log;
  logic [2:0]  req_n;
  int          vcnt;
  logic [63:0] log_addr [4];
  logic [63:0] log_wdata[4];
  logic [7:0]  log_strb [4];
  logic        log_we   [4];

  always @(posedge clk) begin
    dmem_rsp_valid <= 1'b0;
    dmem_rsp_err   <= 1'b0;
    if (clr_log) begin
      req_n <= '0;
      vcnt  <= 0;
    end else begin
      if (dmem_req_valid) vcnt <= vcnt + 1;
      if (inject_rsp) begin
        dmem_rsp_valid <= 1'b1;
        dmem_rsp_rdata <= 64'hDEAD_BEEF_0BAD_F00D;
      end else if (dmem_req_valid && dmem_req_ready) begin
        if (req_n < 3'd4) begin
          log_addr[req_n[1:0]]  <= dmem_req_addr;
          log_wdata[req_n[1:0]] <= dmem_req_wdata;
          log_strb[req_n[1:0]]  <= dmem_req_strb;
          log_we[req_n[1:0]]    <= dmem_req_we;
        end
        req_n <= req_n + 3'd1;
        if (!no_rsp) begin
          dmem_rsp_valid <= 1'b1;
          dmem_rsp_rdata <= (req_n == 3'd0) ? rd0 : rd1;
          dmem_rsp_err   <= (int'(req_n) == err_beat);
        end
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 64'(dmem_req_valid), 64'd0);
    check({tag, "_we"},    64'(dmem_req_we),    64'd0);
    check({tag, "_addr"},  dmem_req_addr,       64'd0);
    check({tag, "_wdata"}, dmem_req_wdata,      64'd0);
    check({tag, "_strb"},  64'(dmem_req_strb),  64'd0);
    check({tag, "_stall"}, 64'(lsu_stall),      64'd0);
    check({tag, "_done"},  64'(lsu_done),       64'd0);
    check({tag, "_ldata"}, load_data_M,         64'd0);
    check({tag, "_fault"}, 64'(lsu_fault),      64'd0);
    check({tag, "_fpc"},   fault_pc,            64'd0);
    check({tag, "_faddr"}, fault_addr,          64'd0);
  endtask

  // Issue one op from IDLE; returns cycles from the op-present cycle to lsu_done.
  task automatic do_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] d, input logic [63:0] pc,
                       input int hold_n, input logic [63:0] hold_addr,
                       input logic [7:0] hold_strb, output int lat);
    @(posedge clk);
    @(negedge clk);
    mem_read_M     = rd;
    mem_write_M    = wr;
    funct3_M       = f3;
    alu_out_M      = a;
    rs2_data_M     = d;
    current_pc_M   = pc;
    clr_log        = 1'b1;
    dmem_req_ready = (hold_n == 0);
    #1;
    check({tag, "_stall_c"}, 64'(lsu_stall), 64'd1);
    @(posedge clk);
    #1;
    mem_read_M  = 1'b0;
    mem_write_M = 1'b0;
    clr_log     = 1'b0;
    lat = 1;
    for (int i = 0; i < hold_n; i++) begin
      check({tag, "_hold_valid"}, 64'(dmem_req_valid), 64'd1);
      check({tag, "_hold_addr"},  dmem_req_addr,       hold_addr);
      check({tag, "_hold_strb"},  64'(dmem_req_strb),  64'(hold_strb));
      @(posedge clk);
      #1;
      lat++;
    end
    dmem_req_ready = 1'b1;
    while (!lsu_done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_done_seen"}, 64'(lsu_done), 64'd1);
  endtask

  int lat;

  initial begin
    rst = 1'b1;
    mem_read_M = 1'b0; mem_write_M = 1'b0; funct3_M = 3'b000;
    alu_out_M = '0; rs2_data_M = '0; current_pc_M = '0;
    dmem_req_ready = 1'b1;
    rd0 = '0; rd1 = '0; err_beat = -1;
    no_rsp = 1'b0; inject_rsp = 1'b0; clr_log = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;

    // LD aligned
    rd0 = 64'h1122_3344_5566_7788;
    do_op("ld", 1, 0, 3'b011, 64'h1000, 0, 64'h100, 0, 0, 0, lat);
    check("ld_lat",   64'(lat),          64'd3);
    check("ld_data",  load_data_M,       64'h1122_3344_5566_7788);
    check("ld_beats", 64'(req_n),        64'd1);
    check("ld_strb",  64'(log_strb[0]),  64'hFF);
    check("ld_addr",  log_addr[0],       64'h1000);
    check("ld_fault", 64'(lsu_fault),    64'd0);

    // LB / LBU lane 3
    rd0 = 64'h0000_0000_8000_0000;
    do_op("lb", 1, 0, 3'b000, 64'h1003, 0, 64'h104, 0, 0, 0, lat);
    check("lb_strb", 64'(log_strb[0]), 64'h08);
    check("lb_addr", log_addr[0],      64'h1000);
    check("lb_data", load_data_M,      64'hFFFF_FFFF_FFFF_FF80);
    do_op("lbu", 1, 0, 3'b100, 64'h1003, 0, 64'h108, 0, 0, 0, lat);
    check("lbu_data", load_data_M, 64'h0000_0000_0000_0080);

    // SW split across the 8-byte boundary
    do_op("sw", 0, 1, 3'b010, 64'h1006, 64'hAABB_CCDD, 64'h10C, 0, 0, 0, lat);
    check("sw_lat",    64'(lat),          64'd5);
    check("sw_beats",  64'(req_n),        64'd2);
    check("sw_we",     64'(log_we[0]),    64'd1);
    check("sw_addr1",  log_addr[0],       64'h1000);
    check("sw_strb1",  64'(log_strb[0]),  64'hC0);
    check("sw_wdata1", log_wdata[0],      64'hCCDD_0000_0000_0000);
    check("sw_addr2",  log_addr[1],       64'h1008);
    check("sw_strb2",  64'(log_strb[1]),  64'h03);
    check("sw_wdata2", log_wdata[1],      64'h0000_0000_0000_AABB);

    // LH split with ready held low for 3 cycles
    rd0 = 64'h3400_0000_0000_0000;
    rd1 = 64'h0000_0000_0000_0012;
    do_op("lh", 1, 0, 3'b001, 64'h2007, 0, 64'h110, 3, 64'h2000, 8'h80, lat);
    check("lh_lat",   64'(lat),         64'd8);
    check("lh_addr2", log_addr[1],      64'h2008);
    check("lh_strb2", 64'(log_strb[1]), 64'h01);
    check("lh_data",  load_data_M,      64'h0000_0000_0000_1234);

    // LD with bus error on beat 1 of a split access
    rd0 = 64'h5555_5555_5555_5555;
    err_beat = 0;
    do_op("lderr", 1, 0, 3'b011, 64'h3004, 0, 64'h8000_0040, 0, 0, 0, lat);
    err_beat = -1;
    check("lderr_lat",   64'(lat),       64'd3);
    check("lderr_fault", 64'(lsu_fault), 64'd1);
    check("lderr_faddr", fault_addr,     64'h3004);
    check("lderr_fpc",   fault_pc,       64'h8000_0040);
    check("lderr_data",  load_data_M,    64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("lderr_beats", 64'(req_n),     64'd1);
    check("lderr_pulse", 64'(lsu_fault), 64'd0);

    // Illegal load funct3
    do_op("ill", 1, 0, 3'b111, 64'h4444, 0, 64'h8000_0080, 0, 0, 0, lat);
    check("ill_lat",   64'(lat),       64'd1);
    check("ill_fault", 64'(lsu_fault), 64'd1);
    check("ill_faddr", fault_addr,     64'h4444);
    check("ill_fpc",   fault_pc,       64'h8000_0080);
    check("ill_vcnt",  64'(vcnt),      64'd0);

    // Reset while in WAIT, then a late response
    @(posedge clk);
    @(negedge clk);
    mem_read_M = 1'b1; funct3_M = 3'b011; alu_out_M = 64'h5000;
    current_pc_M = 64'h200; no_rsp = 1'b1; clr_log = 1'b1;
    @(posedge clk);
    #1;
    mem_read_M = 1'b0; clr_log = 1'b0;
    @(posedge clk);
    #1;
    check("rst_inwait_stall", 64'(lsu_stall), 64'd1);
    rst = 1'b1;
    #1;
    check_quiet("rstwait");
    @(negedge clk);
    rst = 1'b0;
    no_rsp = 1'b0;
    inject_rsp = 1'b1;
    @(posedge clk);
    #1;
    inject_rsp = 1'b0;
    check("late_rsp_seen", 64'(dmem_rsp_valid), 64'd1);
    check("late_stall",    64'(lsu_stall),      64'd0);
    @(posedge clk);
    #1;
    check("late_done",  64'(lsu_done),       64'd0);
    check("late_valid", 64'(dmem_req_valid), 64'd0);

    rd0 = 64'h0123_4567_89AB_CDEF;
    do_op("ld2", 1, 0, 3'b011, 64'h1000, 0, 64'h204, 0, 0, 0, lat);
    check("ld2_lat",  64'(lat),    64'd3);
    check("ld2_data", load_data_M, 64'h0123_4567_89AB_CDEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit; consumes the EX/MEM pipeline register outputs (alu_out_M as address, rs2_data_M as store data, current_pc_M).
- Issues valid/ready requests to the data memory and aligns load data (RV64I byte/half/word/dword, signed/unsigned).
- Splits accesses that cross an 8-byte boundary into two beats.
- Holds the pipeline with lsu_stall until the access completes.

Parameters:
- XLEN, 64, datapath and address width
- BEAT_BYTES, 8, bytes per memory beat; fixed at 8 for this revision

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_read_M  in  1  load in MEM stage
- mem_write_M  in  1  store in MEM stage
- funct3_M  in  3  access size/sign code
- alu_out_M  in  64  effective byte address
- rs2_data_M  in  64  store data, LSB-aligned
- current_pc_M  in  64  PC of MEM-stage instruction
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_we  out  1  1=write, 0=read
- dmem_req_addr  out  64  8-byte-aligned beat address
- dmem_req_wdata  out  64  lane-positioned write data
- dmem_req_strb  out  8  byte-enable per lane
- dmem_rsp_valid  in  1  response beat valid (reads and writes both respond)
- dmem_rsp_rdata  in  64  read data
- dmem_rsp_err  in  1  bus error with response
- lsu_stall  out  1  hold IF..MEM stages
- lsu_done  out  1  one-cycle completion pulse
- load_data_M  out  64  aligned, extended load result, valid with lsu_done
- lsu_fault  out  1  one-cycle fault pulse, coincident with lsu_done
- fault_pc  out  64  PC of last faulting access
- fault_addr  out  64  address of last faulting access

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0, including fault_pc, fault_addr and load_data_M.
  - Reset mid-access drops dmem_req_valid immediately.
  - Any response arriving in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On mem_read_M or mem_write_M, capture op, funct3, address, data and PC, then go to REQ.
  - lsu_stall is asserted combinationally in this same cycle.
  - If both read and write are asserted, execute as a load.
- Illegal funct3:
  - Loads: 111. Stores: 1xx.
  - Go IDLE -> DONE with no memory request; lsu_fault=1.
- REQ:
  - dmem_req_valid=1; all request fields are stable while valid and !ready.
  - When valid & ready, go to WAIT.
- WAIT:
  - On dmem_rsp_valid & !err: if a second beat is pending, go to REQ for beat 2; otherwise go to DONE.
  - On dmem_rsp_valid & err: go to DONE with fault. Beat 2 is never issued.
- DONE:
  - lsu_done=1 and lsu_stall=0 for one cycle, then IDLE.
  - A new op is accepted only in the cycle after DONE.
- lsu_stall = (IDLE & op present) | REQ | WAIT.
- Sizes:
  - Bytes by funct3[1:0]: 1, 2, 4, 8.
  - Offset = addr[2:0]; split when offset + size > 8.
- Beat 1: addr = {addr[63:3], 3'b0}; strb = low (8-offset) bytes of the size mask, shifted left by offset.
- Beat 2: addr = beat 1 addr + 8, wrapping mod 2^64; strb = the remaining low bytes.
- Write data: the 128-bit value {64'b0, rs2} << (offset*8); beat 1 takes the low half, beat 2 the high half.
- Load data:
  - Form {rdata_beat2, rdata_beat1} >> (offset*8); rdata_beat2 is 0 when there is no split.
  - Truncate to size; sign-extend for funct3[2]=0, zero-extend for funct3[2]=1.
- Latency with zero-wait memory (ready=1, response one cycle after accept):
  - Unsplit access: 3 cycles from the op-present IDLE cycle to lsu_done.
  - Split access: 5 cycles.
- Fault:
  - fault_pc and fault_addr load the captured values and hold until the next fault.
  - load_data_M=0.
  - A store faulting on beat 2 leaves beat 1 already written; no rollback.

Decomposition:
- Existing package DEF gains:
  - lsu_state_t enum.
  - funct3 constants F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
  - BEAT_BYTES localparam.
  - dw stays the 64-bit type.
- One combinational sub-module lsu_load_align (128-bit shift, truncate, extend).
- FSM, strobe and write-data generation stay in mem_stage_lsu.

Test Plan:
- LD at addr 0x1000, rdata 0x1122334455667788, zero-wait -> single beat, strb 0xFF, lsu_done in cycle 3, load_data_M 0x1122334455667788.
- LB at 0x1003, rdata byte lane 3 = 0x80 -> strb 0x08, load_data_M 0xFFFFFFFFFFFFFF80; LBU at the same address -> 0x0000000000000080.
- SW at 0x1006, rs2 0xAABBCCDD -> beat 1: addr 0x1000, strb 0xC0, wdata[63:48]=0xCCDD; beat 2: addr 0x1008, strb 0x03, wdata[15:0]=0xAABB; lsu_done in cycle 5.
- LH at 0x2007 (split), beat 1 lane 7 = 0x34, beat 2 lane 0 = 0x12, with ready held low 3 cycles -> request fields stable while waiting, load_data_M 0x0000000000001234.
- LD at 0x3004 with err on beat 1 -> no beat 2, lsu_fault=1, fault_addr 0x3004, fault_pc = current_pc_M; load with funct3 111 -> fault and no dmem_req_valid.
- Assert rst while in WAIT, then send a late rsp_valid -> all outputs 0, state IDLE, response ignored, next LD completes normally.
